// File: rtl/alu_div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: FSM encoding,
// divide opcodes and default sizing.
package alu_div_sequencer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic [3:0] ALU_DIV  = 4'hC;
  localparam logic [3:0] ALU_DIVU = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_div_sequencer_sub_borrow_w.sv
// N-bit ripple subtractor: o_diff = i_r1 + ~i_r2 + i_cin.
// o_cout == 0 means a borrow occurred (i_r1 < i_r2 when i_cin == 1).
module sub_borrow_w #(
  parameter int N = 33
) (
  input  logic [N-1:0] i_r1,
  input  logic [N-1:0] i_r2,
  input  logic         i_cin,
  output logic [N-1:0] o_diff,
  output logic         o_cout
);

  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < N; g++) begin : g_bit
    logic w_b;
    assign w_b       = ~i_r2[g];
    assign o_diff[g] = i_r1[g] ^ w_b ^ w_c[g];
    assign w_c[g+1]  = (i_r1[g] & w_b) | (w_c[g] & (i_r1[g] ^ w_b));
  end

  assign o_cout = w_c[N];

endmodule

// File: rtl/alu_div_sequencer.sv
// Restoring divider: one shared subtractor iterated WIDTH times, then a sign
// fix-up cycle. Handshake: a transfer happens on any edge where valid && ready.
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz,
  output logic [1:0]       o_dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_dividend;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz;
  logic [WIDTH-1:0] r_out_quot;
  logic [WIDTH-1:0] r_out_rem;
  logic             r_out_valid;
  logic             r_out_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_cout;
  logic             w_fits;

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_a_neg    = in_signed & in_dividend[WIDTH-1];
  assign w_b_neg    = in_signed & in_divisor[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -in_dividend : in_dividend;
  assign w_b_mag    = w_b_neg ? -in_divisor : in_divisor;
  assign w_div_zero = (in_divisor == '0);

  // Partial remainder is WIDTH+1 bits wide once the quotient MSB shifts in.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};

  sub_borrow_w #(.N(WIDTH + 1)) u_sub (
    .i_r1   (w_rem_sh),
    .i_r2   ({1'b0, r_div}),
    .i_cin  (1'b1),
    .o_diff (w_trial),
    .o_cout (w_cout)
  );

  // With no borrow the difference is below the divisor, so its MSB is zero.
  assign w_fits = w_cout & ~w_trial[WIDTH];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = w_div_zero ? ST_FIX : ST_ITER;
      ST_ITER: if (w_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_dividend  <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dbz       <= 1'b0;
      r_out_quot  <= '0;
      r_out_rem   <= '0;
      r_out_valid <= 1'b0;
      r_out_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_div      <= w_b_mag;
            r_dividend <= in_dividend;
            r_sign_q   <= w_a_neg ^ w_b_neg;
            r_sign_r   <= w_a_neg;
            r_dbz      <= w_div_zero;
          end
        end
        ST_ITER: begin
          r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_out_valid <= 1'b1;
          r_out_dbz   <= r_dbz;
          // Divide-by-zero returns all-ones and the untouched dividend bits.
          if (r_dbz) begin
            r_out_quot <= '1;
            r_out_rem  <= r_dividend;
          end else begin
            r_out_quot <= r_sign_q ? -r_quo : r_quo;
            r_out_rem  <= r_sign_r ? -r_rem : r_rem;
          end
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = r_out_valid;
  assign out_quot    = r_out_quot;
  assign out_rem     = r_out_rem;
  assign out_dbz     = r_out_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for the divide sequencer: driver pushes expected results,
// an independent monitor pops and compares them when out_valid is presented.
module tb_alu_div_sequencer;
  import alu_div_sequencer_pkg::*;

  localparam int W  = 32;
  localparam int EW = 2 * W + 1 + 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;
  logic         out_dbz;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur;
  bit            seen = 0;

  alu_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_rem     (out_rem),
    .out_dbz     (out_dbz),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver
  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit push, input logic [W-1:0] eq, input logic [W-1:0] er,
                      input logic ed, input logic [7:0] elat);
    int t;
    @(negedge clk);
    in_signed   = s;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    if (push) exp_q.push_back({eq, er, ed, elat});
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk);
    accept_cyc = cyc;
    #1;
    in_valid    = 1'b0;
    in_signed   = 1'($urandom_range(0, 1));
    in_dividend = $urandom;
    in_divisor  = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: quot 0x%0h rem 0x%0h with no pending request", out_quot, out_rem);
        end else begin
          cur  = exp_q.pop_front();
          seen = 1;
          check("quot", 64'(out_quot), 64'(cur[EW-1 -: W]));
          check("rem", 64'(out_rem), 64'(cur[EW-1-W -: W]));
          check("dbz", 64'(out_dbz), 64'(cur[8]));
          check("latency", 64'(cyc - accept_cyc - 1), 64'(cur[7:0]));
        end
      end else begin
        check("hold_quot", 64'(out_quot), 64'(cur[EW-1 -: W]));
        check("hold_rem", 64'(out_rem), 64'(cur[EW-1-W -: W]));
        check("hold_dbz", 64'(out_dbz), 64'(cur[8]));
      end
      if (out_ready) seen = 0;
    end else begin
      seen = 0;
    end
  end

  initial begin
    int t;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_signed   = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quot", 64'(out_quot), 64'd0);
    check("rst_rem", 64'(out_rem), 64'd0);
    check("rst_dbz", 64'(out_dbz), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    send(1'b0, 32'd100,        32'd7,        1, 32'd14,       32'd2,        1'b0, 8'd33);
    send(1'b1, 32'hFFFFFF9C,   32'd7,        1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 8'd33);
    send(1'b1, 32'd100,        32'hFFFFFFF9, 1, 32'hFFFFFFF2, 32'd2,        1'b0, 8'd33);
    send(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 1, 32'd14,       32'hFFFFFFFE, 1'b0, 8'd33);
    send(1'b0, 32'h12345678,   32'd0,        1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 8'd1);
    send(1'b1, 32'h80000001,   32'd0,        1, 32'hFFFFFFFF, 32'h80000001, 1'b1, 8'd1);
    send(1'b1, 32'h80000000,   32'hFFFFFFFF, 1, 32'h80000000, 32'd0,        1'b0, 8'd33);
    send(1'b0, 32'h80000000,   32'hFFFFFFFF, 1, 32'd0,        32'h80000000, 1'b0, 8'd33);
    send(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 1, 32'd1,        32'd0,        1'b0, 8'd33);
    send(1'b0, 32'd7,          32'd100,      1, 32'd0,        32'd7,        1'b0, 8'd33);
    send(1'b1, 32'd7,          32'hFFFFFF9C, 1, 32'd0,        32'd7,        1'b0, 8'd33);
    send(1'b0, 32'hDEADBEEF,   32'h10,       1, 32'h0DEADBEE, 32'hF,        1'b0, 8'd33);
    drain();

    // backpressure: result held, new requests ignored
    out_ready = 1'b0;
    send(1'b0, 32'd1000, 32'd3, 1, 32'd333, 32'd1, 1'b0, 8'd33);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_signed   = 1'b0;
      in_dividend = $urandom;
      in_divisor  = 32'd5;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_state", 64'(dbg_state), 64'(ST_DONE));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);
    check("bp_no_extra_valid", 64'(out_valid), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset in the middle of an iteration discards the request
    send(1'b0, 32'd5000, 32'd3, 0, 32'd0, 32'd0, 1'b0, 8'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_state_iter", 64'(dbg_state), 64'(ST_ITER));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_quot", 64'(out_quot), 64'd0);
    check("mid_rst_rem", 64'(out_rem), 64'd0);
    send(1'b0, 32'hFFFFFFFF, 32'd1, 1, 32'hFFFFFFFF, 32'd0, 1'b0, 8'd33);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
